// File: rtl/sm_regdump_tx_pkg.sv
// Shared types and framing constants for the register-dump UART transmitter.
package sm_regdump_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETADDR = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    localparam int BYTES_PER_REG  = 5;
    localparam int BITS_PER_FRAME = 10;

endpackage

// File: rtl/sm_regdump_tx_if.sv
// Debug register port bundle: dump control, register address/data pair, serial line.
interface sm_regdump_tx_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        tx;

    modport master (input start, regData, output busy, done, regAddr, tx);
    modport slave  (output start, regData, input busy, done, regAddr, tx);
endinterface

// File: rtl/sm_regdump_tx_uart.sv
// Single 8N1 frame transmitter; ready is high during idle and the last cycle of the stop bit.
module sm_uart_tx_byte
    import sm_regdump_tx_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    logic        active;
    logic [15:0] baudCnt;
    logic [3:0]  bitCnt;
    logic [7:0]  shReg;
    logic        bitEnd;

    assign bitEnd = (baudCnt == 16'(BAUD_DIV - 1));
    // Signalling ready in the final stop-bit cycle lets the next load land with no gap.
    assign ready  = !active || (bitEnd && bitCnt == 4'(BITS_PER_FRAME - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            baudCnt <= '0;
            bitCnt  <= '0;
            shReg   <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            active  <= 1'b1;
            baudCnt <= '0;
            bitCnt  <= '0;
            shReg   <= data;
            tx      <= 1'b0;
        end else if (active) begin
            if (bitEnd) begin
                baudCnt <= '0;
                if (bitCnt == 4'(BITS_PER_FRAME - 1)) begin
                    active <= 1'b0;
                    bitCnt <= '0;
                    tx     <= 1'b1;
                end else begin
                    // Ones shifted in at the top supply the stop bit after data bit 7.
                    bitCnt <= bitCnt + 4'd1;
                    tx     <= shReg[0];
                    shReg  <= {1'b1, shReg[7:1]};
                end
            end else begin
                baudCnt <= baudCnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sm_regdump_tx.sv
// Walks regAddr over the register file and streams address + big-endian data as UART bytes.
module sm_regdump_tx
    import sm_regdump_tx_pkg::*;
#(
    parameter int BAUD_DIV = 16,
    parameter int NREGS    = 32
) (
    input logic              clk,
    input logic              rst,
    sm_regdump_tx_if.master  bus
);

    state_t      state;
    logic [2:0]  byteIdx;
    logic [31:0] dataSr;
    logic        load;
    logic [7:0]  loadData;
    logic        uReady;

    // Byte 0 goes out straight from the address; data bytes come off the top of dataSr.
    always_comb begin
        load     = 1'b0;
        loadData = dataSr[31:24];
        if (state == S_SETADDR) begin
            load     = 1'b1;
            loadData = {3'b0, bus.regAddr};
        end else if (state == S_SEND && uReady && byteIdx < 3'(BYTES_PER_REG - 1)) begin
            load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.regAddr <= '0;
            byteIdx     <= '0;
            dataSr      <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.busy    <= 1'b1;
                        bus.regAddr <= '0;
                        state       <= S_SETADDR;
                    end
                end
                S_SETADDR: begin
                    dataSr  <= bus.regData;
                    byteIdx <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (uReady) begin
                        if (byteIdx < 3'(BYTES_PER_REG - 1)) begin
                            byteIdx <= byteIdx + 3'd1;
                            dataSr  <= {dataSr[23:0], 8'h00};
                        end else if (bus.regAddr < 5'(NREGS - 1)) begin
                            bus.regAddr <= bus.regAddr + 5'd1;
                            state       <= S_SETADDR;
                        end else begin
                            bus.busy    <= 1'b0;
                            bus.done    <= 1'b1;
                            bus.regAddr <= '0;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sm_uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) uTx (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (loadData),
        .tx    (bus.tx),
        .ready (uReady)
    );

endmodule

// File: tb/tb_sm_regdump_tx.sv
// Directed bench: three DUT configurations, UART decode of the serial lines, timing checks.
module tb_sm_regdump_tx;

    logic clk, rst;
    logic startA, startB, startC;
    logic [31:0] dA;
    logic scramble;
    int cyc = 0;
    int total = 0, bad = 0;
    int doneCntA = 0, doneCycA = 0, doneCntB = 0, doneCycB = 0;
    logic [2:0] txv;

    sm_regdump_tx_if ifA ();
    sm_regdump_tx_if ifB ();
    sm_regdump_tx_if ifC ();

    sm_regdump_tx #(.BAUD_DIV(2), .NREGS(1))  dutA (.clk(clk), .rst(rst), .bus(ifA.master));
    sm_regdump_tx #(.BAUD_DIV(1), .NREGS(32)) dutB (.clk(clk), .rst(rst), .bus(ifB.master));
    sm_regdump_tx #(.BAUD_DIV(1), .NREGS(1))  dutC (.clk(clk), .rst(rst), .bus(ifC.master));

    assign ifA.start   = startA;
    assign ifA.regData = scramble ? 32'(cyc) * 32'h9E3779B1 : dA;
    assign ifB.start   = startB;
    assign ifB.regData = {27'b0, ifB.regAddr} * 32'd3;
    assign ifC.start   = startC;
    assign ifC.regData = 32'hCAFE0001;
    assign txv = {ifC.tx, ifB.tx, ifA.tx};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifA.done === 1'b1) begin doneCntA++; doneCycA = cyc; end
        if (ifB.done === 1'b1) begin doneCntB++; doneCycB = cyc; end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic recvByte(input int d, input int bd, output logic [7:0] b);
        int n = 0;
        b = '0;
        @(negedge clk);
        while (txv[d] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $error("FAIL rx_timeout line=%0d observed=no_start expected=start_bit", d);
            return;
        end
        for (int j = 0; j < 8; j++) begin
            repeat (bd) @(negedge clk);
            b[j] = txv[d];
        end
        repeat (bd) @(negedge clk);
        check("stop_bit", 64'(txv[d]), 64'd1);
    endtask

    task automatic waitDone(input int which, input int target, input int limit);
        int n = 0;
        while (((which == 0) ? doneCntA : doneCntB) < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp5[5];
        logic [31:0] w;
        int e0, c0, t1, t2, n;

        rst = 1'b1; startA = 0; startB = 0; startC = 0; dA = '0; scramble = 0;
        repeat (3) @(negedge clk);
        check("rst_tx",      64'(ifA.tx),      64'd1);
        check("rst_busy",    64'(ifA.busy),    64'd0);
        check("rst_done",    64'(ifA.done),    64'd0);
        check("rst_regAddr", 64'(ifB.regAddr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // NREGS=1, BAUD_DIV=2, fixed word
        dA = 32'h12345678;
        exp5 = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        startA = 1; @(negedge clk); startA = 0; e0 = cyc;
        check("t2_busy", 64'(ifA.busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            recvByte(0, 2, b);
            check("t2_byte", 64'(b), 64'(exp5[i]));
        end
        waitDone(0, 1, 500);
        check("t2_done_cnt", 64'(doneCntA), 64'd1);
        check("t2_done_cyc", 64'(doneCycA - e0), 64'd101);
        check("t2_busy_end", 64'(ifA.busy), 64'd0);
        check("t2_done_end", 64'(ifA.done), 64'd0);

        // NREGS=32, BAUD_DIV=1, regData = regAddr*3
        startB = 1; @(negedge clk); startB = 0; e0 = cyc;
        for (int k = 0; k < 32; k++) begin
            recvByte(1, 1, b);
            check("t3_addr", 64'(b), 64'(k));
            for (int m = 3; m >= 0; m--) begin
                recvByte(1, 1, b);
                check("t3_data", 64'(b), 64'(((k * 3) >> (8 * m)) & 8'hFF));
            end
        end
        waitDone(1, 1, 200);
        check("t3_done_cnt", 64'(doneCntB), 64'd1);
        check("t3_done_cyc", 64'(doneCycB - e0), 64'd1632);
        check("t3_busy_end", 64'(ifB.busy), 64'd0);
        check("t3_addr_end", 64'(ifB.regAddr), 64'd0);

        // regData changes every cycle; frame must carry the SETADDR-cycle value
        scramble = 1;
        startA = 1; @(negedge clk); startA = 0; e0 = cyc;
        w = 32'(e0) * 32'h9E3779B1;
        exp5 = '{8'h00, w[31:24], w[23:16], w[15:8], w[7:0]};
        for (int i = 0; i < 5; i++) begin
            recvByte(0, 2, b);
            check("t5_byte", 64'(b), 64'(exp5[i]));
        end
        waitDone(0, 2, 500);
        check("t5_done_cnt", 64'(doneCntA), 64'd2);
        scramble = 0;

        // start pulses while busy are ignored
        c0 = doneCntA;
        startA = 1; @(negedge clk); startA = 0; e0 = cyc;
        repeat (9) @(negedge clk);
        startA = 1; @(negedge clk); startA = 0;
        repeat (39) @(negedge clk);
        startA = 1; @(negedge clk); startA = 0;
        repeat (150) @(negedge clk);
        check("t4_one_done", 64'(doneCntA - c0), 64'd1);
        check("t4_done_cyc", 64'(doneCycA - e0), 64'd101);
        check("t4_idle",     64'(ifA.busy), 64'd0);

        // start held: back-to-back dumps
        startC = 1;
        n = 0;
        while (ifC.done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("t6_done1", 64'(ifC.done), 64'd1);
        t1 = cyc;
        check("t6_busy_at_done", 64'(ifC.busy), 64'd0);
        @(negedge clk);
        check("t6_busy_rise", 64'(ifC.busy), 64'd1);
        check("t6_done_clear", 64'(ifC.done), 64'd0);
        n = 0;
        while (ifC.done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("t6_done2", 64'(ifC.done), 64'd1);
        t2 = cyc;
        check("t6_spacing", 64'(t2 - t1), 64'd52);
        startC = 0;
        repeat (60) @(negedge clk);

        // asynchronous reset mid-frame
        startB = 1; @(negedge clk); startB = 0;
        repeat (300) @(negedge clk);
        n = 0;
        while (txv[1] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("t1_pre_tx",   64'(ifB.tx), 64'd0);
        check("t1_pre_busy", 64'(ifB.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_tx",      64'(ifB.tx),      64'd1);
        check("t1_busy",    64'(ifB.busy),    64'd0);
        check("t1_done",    64'(ifB.done),    64'd0);
        check("t1_regAddr", 64'(ifB.regAddr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_stay_idle", 64'(ifB.busy), 64'd0);
        check("t1_stay_tx",   64'(ifB.tx),   64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
